// File: rtl/mips_pkg.sv
// Constants shared across the single-cycle MIPS datapath blocks.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports, one clocked write port,
// with optional hardwired-zero register 0.
module reg_file #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    import mips_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [ADDR_W-1:0] readIdx_s [2];
    logic [DATA_W-1:0] readData_s [2];
    logic              writeEn_s;

    // Writes to the hardwired-zero index are dropped before they reach storage.
    always_comb begin
        writeEn_s = 1'b0;
        if (ZERO_REG && (WriteReg == ZERO_IDX)) begin
            writeEn_s = 1'b0;
        end else begin
            writeEn_s = RegWrite;
        end
    end

    // Register storage: synchronous clear takes priority over any write in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (writeEn_s) begin
            regs_r[WriteReg] <= WriteData;
        end
    end

    assign readIdx_s[0] = ReadReg1;
    assign readIdx_s[1] = ReadReg2;

    // Both read ports come from this single loop body so masking is identical on each.
    for (genvar p = 0; p < 2; p++) begin : g_readPort
        // Combinational read mux with zero-register masking.
        always_comb begin
            readData_s[p] = '0;
            if (ZERO_REG && (readIdx_s[p] == ZERO_IDX)) begin
                readData_s[p] = '0;
            end else begin
                readData_s[p] = regs_r[readIdx_s[p]];
            end
        end
    end

    assign ReadData1 = readData_s[0];
    assign ReadData2 = readData_s[1];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// checked against an array-based model of the register file.
module tb_reg_file;

    logic        clock;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [32];

    reg_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Architectural view: register 0 always reads zero, others read what was last written.
    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        return model[idx];
    endfunction

    // Apply one clock edge and update the model the way the ISA says a write behaves.
    task automatic clockEdge();
        @(posedge clock);
        #1;
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (RegWrite && WriteReg != 5'd0) begin
            model[WriteReg] = WriteData;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd9; WriteData = $urandom;
        clockEdge();
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
            #1;
            checks++;
            if (ReadData1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep_p1 idx=%0d got=%h exp=%h", i, ReadData1, 32'h0);
            end
            checks++;
            if (ReadData2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep_p2 idx=%0d got=%h exp=%h", 31 - i, ReadData2, 32'h0);
            end
        end
    endtask

    task automatic test_write_basic();
        RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'h0000_0007;
        clockEdge();
        RegWrite = 1'b0; ReadReg1 = 5'd1; ReadReg2 = 5'd2;
        #1;
        checks++;
        if (ReadData1 !== 32'h0000_0007) begin
            errors++;
            $display("FAIL write_basic_r1 got=%h exp=%h", ReadData1, 32'h0000_0007);
        end
        checks++;
        if (ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL write_basic_r2 got=%h exp=%h", ReadData2, 32'h0);
        end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h0000_0007;
        clockEdge();
        RegWrite = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_r1 got=%h exp=%h", ReadData1, 32'h0);
        end
        checks++;
        if (ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_r2 got=%h exp=%h", ReadData2, 32'h0);
        end
    endtask

    task automatic test_write_disable();
        RegWrite = 1'b0; WriteReg = 5'd3; WriteData = 32'hDEAD_BEEF;
        clockEdge();
        ReadReg1 = 5'd3;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin
            errors++;
            $display("FAIL write_disable got=%h exp=%h", ReadData1, 32'h0);
        end
    endtask

    task automatic test_no_bypass();
        logic [31:0] oldVal;
        oldVal = expRead(5'd5);
        ReadReg1 = 5'd5; ReadReg2 = 5'd5;
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (ReadData1 !== oldVal || ReadData2 !== oldVal) begin
            errors++;
            $display("FAIL no_bypass_before got=%h/%h exp=%h", ReadData1, ReadData2, oldVal);
        end
        clockEdge();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'hA5A5_A5A5 || ReadData2 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL no_bypass_after got=%h/%h exp=%h", ReadData1, ReadData2, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            RegWrite  = 1'($urandom_range(0, 1));
            WriteReg  = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            ReadReg1  = 5'($urandom_range(0, 31));
            ReadReg2  = (n % 4 == 0) ? WriteReg : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (ReadData1 !== expRead(ReadReg1)) begin
                errors++;
                $display("FAIL random_r1 n=%0d idx=%0d got=%h exp=%h", n, ReadReg1, ReadData1, expRead(ReadReg1));
            end
            checks++;
            if (ReadData2 !== expRead(ReadReg2)) begin
                errors++;
                $display("FAIL random_r2 n=%0d idx=%0d got=%h exp=%h", n, ReadReg2, ReadData2, expRead(ReadReg2));
            end
            clockEdge();
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_reset_priority();
        for (int i = 1; i < 32; i++) begin
            RegWrite = 1'b1; WriteReg = 5'(i); WriteData = 32'(i);
            clockEdge();
        end
        RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd4;
        #1;
        checks++;
        if (ReadData1 !== 32'd31 || ReadData2 !== 32'd4) begin
            errors++;
            $display("FAIL load_index got=%h/%h exp=%h/%h", ReadData1, ReadData2, 32'd31, 32'd4);
        end
        reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'hFFFF_FFFF;
        clockEdge();
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i); ReadReg2 = 5'(i);
            #1;
            checks++;
            if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_priority idx=%0d got=%h/%h exp=%h", i, ReadData1, ReadData2, 32'h0);
            end
        end
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        WriteReg = 5'd0; WriteData = 32'h0;
        @(negedge clock);
        test_reset();
        test_write_basic();
        test_zero_reg();
        test_write_disable();
        test_no_bypass();
        test_random();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file
